// File: rtl/sipo_rx_pkg.sv
// Shared types and helpers for the serial frame receiver.
package sipo_rx_pkg;

    // Receiver FSM states; the encoding is also exported on state_dbg.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // Reduction XOR of a zero-extended word: 1 when it holds an odd number of ones.
    // Callers zero-extend their data to 64 bits, so DATA_W up to 64 is supported.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/rx_shift_reg.sv
// Shift-in register: each enabled cycle the new bit enters at the MSB and
// older bits move toward bit 0, so after W shifts the first bit sits in bit 0.
module rx_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q
);

    generate
        if (W == 1) begin : g_single
            // A one-bit register simply captures the sample.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  q <= '0;
                else if (en) q <= din;
            end
        end else begin : g_multi
            // Shift right, inserting the new sample at the top.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  q <= '0;
                else if (en) q <= {din, q[W-1:1]};
            end
        end
    endgenerate

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, LSB-first data, optional even parity,
// stop bit; each word is presented through a one-entry holding register.
//
// Handshake: dout_valid stays high with dout/parity_err/frame_err stable
// until the edge where dout_valid && dout_ready; a frame completing on that
// same edge is loaded in place of the consumed word. A frame completing
// while the held word is not being consumed is dropped and overrun pulses.
module sipo_frame_rx
    import sipo_rx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    localparam int              CW   = $clog2(DATA_W + 1);
    localparam logic [CW-1:0]   LAST = CW'(DATA_W - 1);

    rx_state_t         state;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] shift_q;
    logic              par_err_q;
    logic              shift_en;

    assign shift_en  = (state == DATA);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    rx_shift_reg #(.W(DATA_W)) u_shift (
        .clk   (clk),
        .rst_n (rst),
        .en    (shift_en),
        .din   (sin),
        .q     (shift_q)
    );

    // Frame sequencing: bit counter and the parity verdict for the current frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            par_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!sin) begin
                        count <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (count == LAST) state <= PARITY_EN ? PARITY : STOP;
                    else               count <= count + CW'(1);
                end
                PARITY: begin
                    par_err_q <= even_parity(64'(shift_q)) ^ sin;
                    state     <= STOP;
                end
                STOP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Holding register: load on completion when free or being consumed, else flag overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (state == STOP) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= shift_q;
                    parity_err <= PARITY_EN & par_err_q;
                    frame_err  <= !sin;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: an 8-bit parity instance driven through a word
// scoreboard plus directed timing checks, and a 4-bit no-parity instance.
module tb_sipo_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // 8-bit, parity-enabled instance
    logic       sin = 1'b1;
    logic       dout_ready = 1'b0;
    logic [7:0] dout;
    logic       dout_valid, parity_err, frame_err, overrun, busy;
    logic [1:0] state_dbg;

    // 4-bit, no-parity instance
    logic       sin4 = 1'b1;
    logic       dout_ready4 = 1'b1;
    logic [3:0] dout4;
    logic       dout_valid4, parity_err4, frame_err4, overrun4, busy4;
    logic [1:0] state_dbg4;

    int errors = 0;
    int checks = 0;
    int ovr_seen = 0;

    // {parity_err, frame_err, dout}
    logic [9:0] exp_q[$];

    sipo_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .sin(sin), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .busy(busy), .state_dbg(state_dbg)
    );

    sipo_frame_rx #(.DATA_W(4), .PARITY_EN(1'b0)) u_dut4 (
        .clk(clk), .rst(rst), .sin(sin4), .dout(dout4), .dout_valid(dout_valid4),
        .dout_ready(dout_ready4), .parity_err(parity_err4), .frame_err(frame_err4),
        .overrun(overrun4), .busy(busy4), .state_dbg(state_dbg4)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sin = 1'b1;
        end
    endtask

    // Drives start, 8 data bits, parity (optionally inverted) and stop bit.
    // ready is set to rdy_stop together with the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop_bit, input logic rdy_stop,
                              input logic expect_kept);
        @(negedge clk); sin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); sin = d[i];
        end
        @(negedge clk); sin = (^d) ^ par_flip;
        @(negedge clk); sin = stop_bit; dout_ready = rdy_stop;
        if (expect_kept) exp_q.push_back({par_flip, ~stop_bit, d});
    endtask

    task automatic send4(input logic [3:0] d);
        @(negedge clk); sin4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); sin4 = d[i];
        end
        @(negedge clk); sin4 = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"},  32'(dout), 32'd0);
        chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, "_perr"},  32'(parity_err), 32'd0);
        chk({tag, "_ferr"},  32'(frame_err), 32'd0);
        chk({tag, "_ovr"},   32'(overrun), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    // Scoreboard: every accepted word is compared with the oldest expectation.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst && overrun) ovr_seen++;
            if (rst && dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_pending", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_word", {22'd0, parity_err, frame_err, dout}, {22'd0, e});
                end
            end
        end
    end

    initial begin
        logic [7:0] rd;
        logic       rflip, rstop;
        int         wait_n;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        chk("reset_valid4", 32'(dout_valid4), 32'd0);
        chk("reset_busy4",  32'(busy4), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        dout_ready = 1'b1;
        idle(2);

        // Clean frame 0xA5: valid appears 11 cycles after the start edge, for one cycle
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("a5_busy_stop", 32'(busy), 32'd1);
        idle(1);
        #1;
        chk("a5_valid", 32'(dout_valid), 32'd1);
        chk("a5_dout",  32'(dout), 32'hA5);
        chk("a5_busy_after", 32'(busy), 32'd0);
        idle(1);
        #1;
        chk("a5_valid_pulse", 32'(dout_valid), 32'd0);

        // Parity and framing errors travel with the word
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1);
        #1;
        chk("perr_flag", 32'(parity_err), 32'd1);
        idle(1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        #1;
        chk("ferr_flag", 32'(frame_err), 32'd1);
        chk("ferr_dout", 32'(dout), 32'h3C);
        idle(2);

        // Overrun: 0x12 held, back-to-back 0x34 dropped
        @(negedge clk); dout_ready = 1'b0; sin = 1'b1;
        send_frame(8'h12, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'h34, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        #1;
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_held",  32'(dout), 32'h12);
        chk("ovr_valid", 32'(dout_valid), 32'd1);
        idle(1);
        #1;
        chk("ovr_one_cycle", 32'(overrun), 32'd0);
        @(negedge clk); dout_ready = 1'b1;
        idle(1);
        #1;
        chk("ovr_drained", 32'(dout_valid), 32'd0);

        // Consume 0x55 on the very edge 0xAA completes
        @(negedge clk); dout_ready = 1'b0;
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);
        send_frame(8'hAA, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge clk); sin = 1'b1; dout_ready = 1'b0;
        #1;
        chk("sim_valid", 32'(dout_valid), 32'd1);
        chk("sim_dout",  32'(dout), 32'hAA);
        chk("sim_ovr",   32'(overrun), 32'd0);
        @(negedge clk); dout_ready = 1'b1;
        idle(1);
        #1;
        chk("sim_drained", 32'(dout_valid), 32'd0);

        // Reset after 4 data bits, then a clean 0x0F
        @(negedge clk); sin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); sin = 1'(i % 2);
        end
        @(negedge clk); rst = 1'b0; sin = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk); rst = 1'b1;
        idle(3);
        #1;
        chk("midrst_no_word", 32'(dout_valid), 32'd0);
        send_frame(8'h0F, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1);
        #1;
        chk("midrst_0f", 32'(dout), 32'h0F);

        // 4-bit, no-parity instance: 0x9 visible 6 cycles after start
        send4(4'h9);
        @(negedge clk);
        #1;
        chk("w4_valid", 32'(dout_valid4), 32'd1);
        chk("w4_dout",  32'(dout4), 32'h9);
        chk("w4_perr",  32'(parity_err4), 32'd0);
        chk("w4_ferr",  32'(frame_err4), 32'd0);

        // Random words with random error injection, back-to-back or gapped
        for (int n = 0; n < 20; n++) begin
            rd    = 8'($urandom_range(0, 255));
            rflip = ($urandom_range(0, 3) == 0);
            rstop = ($urandom_range(0, 3) != 0);
            send_frame(rd, rflip, rstop, 1'b1, 1'b1);
            if (!rstop || $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(1);

        // Drain with a bounded wait
        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 50) begin
            idle(1);
            wait_n++;
        end
        #1;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        chk("overrun_count", 32'(ovr_seen), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
